// File: rtl/cfg_bus_arbiter.sv
// cfg_bus_arbiter: two-requester (host, lookahead engine) arbiter for the
// configuration-register bus. Each transaction takes three cycles
// (IDLE -> BUS -> ACK); the owner is chosen in IDLE and held until ACK ends.
// Build option: define CFG_ARB_ROUND_ROBIN_EN to alternate winners on
// simultaneous requests; otherwise the lookahead engine always wins a tie.
module cfg_bus_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // host requester
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic                  host_ack,
    output logic [DATA_WIDTH-1:0] host_rdata,
    // lookahead-engine requester
    input  logic                  lse_req,
    input  logic                  lse_we,
    input  logic [ADDR_WIDTH-1:0] lse_addr,
    input  logic [DATA_WIDTH-1:0] lse_wdata,
    output logic                  lse_gnt,
    output logic                  lse_ack,
    output logic [DATA_WIDTH-1:0] lse_rdata,
    // config-register bus
    output logic [ADDR_WIDTH-1:0] cfg_addr,
    output logic                  cfg_write_en,
    output logic [DATA_WIDTH-1:0] cfg_write_data,
    input  logic [DATA_WIDTH-1:0] cfg_read_data,
    // status
    output logic                  busy,
    output logic [15:0]           txn_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        ACK  = 2'd2
    } state_t;

    // owner encoding: 0 = host, 1 = lse
    state_t                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    winner;
    logic [DATA_WIDTH-1:0]   host_rdata_q, host_rdata_d;
    logic [DATA_WIDTH-1:0]   lse_rdata_q, lse_rdata_d;
    logic [15:0]             txn_count_q, txn_count_d;

`ifdef CFG_ARB_ROUND_ROBIN_EN
    // last granted requester; a tie goes to the other one
    logic                    last_q, last_d;

    // Winner selection: a sole requester wins outright, a tie alternates.
    always_comb begin
        winner = lse_req;
        if (host_req && lse_req) begin
            winner = ~last_q;
        end
    end
`else
    // Winner selection: lse wins whenever it requests, host only when alone.
    always_comb begin
        winner = lse_req;
    end
`endif

    // Next-state logic: only IDLE looks at requests; BUS and ACK are fixed steps.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
`ifdef CFG_ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (host_req || lse_req) begin
                    state_d = BUS;
                    owner_d = winner;
`ifdef CFG_ARB_ROUND_ROBIN_EN
                    last_d  = winner;
`endif
                end
            end
            BUS:     state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: the bus is driven only in BUS, and is all-zero otherwise.
    always_comb begin
        host_gnt       = 1'b0;
        lse_gnt        = 1'b0;
        host_ack       = 1'b0;
        lse_ack        = 1'b0;
        cfg_addr       = '0;
        cfg_write_data = '0;
        cfg_write_en   = 1'b0;
        case (state_q)
            BUS: begin
                host_gnt       = ~owner_q;
                lse_gnt        = owner_q;
                cfg_addr       = owner_q ? lse_addr  : host_addr;
                cfg_write_data = owner_q ? lse_wdata : host_wdata;
                cfg_write_en   = owner_q ? lse_we    : host_we;
            end
            ACK: begin
                host_ack = ~owner_q;
                lse_ack  = owner_q;
            end
            default: ;
        endcase
    end

    // Read-data capture and completion counting.
    always_comb begin
        host_rdata_d = host_rdata_q;
        lse_rdata_d  = lse_rdata_q;
        txn_count_d  = txn_count_q;
        if (state_q == BUS) begin
            if (owner_q) begin
                lse_rdata_d = cfg_read_data;
            end else begin
                host_rdata_d = cfg_read_data;
            end
        end
        if (state_q == ACK) begin
            txn_count_d = txn_count_q + 16'd1;
        end
    end

    // State, owner, read-data and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            host_rdata_q <= '0;
            lse_rdata_q  <= '0;
            txn_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            host_rdata_q <= host_rdata_d;
            lse_rdata_q  <= lse_rdata_d;
            txn_count_q  <= txn_count_d;
        end
    end

`ifdef CFG_ARB_ROUND_ROBIN_EN
    // Round-robin pointer; starts at host so the first tie goes to lse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign host_rdata = host_rdata_q;
    assign lse_rdata  = lse_rdata_q;
    assign txn_count  = txn_count_q;
    assign busy       = (state_q != IDLE);

endmodule
